// File: rtl/csr_file.sv
// Machine-mode CSR file: serves CSRRW/CSRRS/CSRRC over a req/rsp handshake,
// holds trap state and the mcycle/minstret counters, exports mtvec/mepc/MIE.
module csr_file #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] HARTID    = '0,
    parameter logic [XLEN-1:0] MISA_VAL  = 32'h4000_0100,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_req_valid_i,
    output logic            csr_req_ready_o,
    input  logic [11:0]     csr_req_addr_i,
    input  logic [1:0]      csr_req_op_i,
    input  logic            csr_req_wen_i,
    input  logic [XLEN-1:0] csr_req_wdata_i,
    output logic            csr_rsp_valid_o,
    input  logic            csr_rsp_ready_i,
    output logic [XLEN-1:0] csr_rsp_rdata_o,
    output logic            csr_rsp_illegal_o,
    input  logic [1:0]      retire_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_tval_i,
    input  logic            mret_i,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_o
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_INSTRET  = 12'hC02;
    localparam logic [11:0] A_MHARTID  = 12'hF14;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t          state_q;
    logic            mie_q, mpie_q;
    logic [XLEN-1:0] mie_reg_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [XLEN-1:0] mcycle_q, minstret_q;
    logic [XLEN-1:0] mstatus_rd, old_val, new_val, ret_inc;
    logic            impl, wr_attempt, illegal, accept, do_write;
    logic [1:0]      ret_sat;

    assign mstatus_rd = {{(XLEN-8){1'b0}}, mpie_q, 3'b000, mie_q, 3'b000};

    always_comb begin
        impl    = 1'b1;
        old_val = '0;
        case (csr_req_addr_i)
            A_MSTATUS:           old_val = mstatus_rd;
            A_MISA:              old_val = MISA_VAL;
            A_MIE:               old_val = mie_reg_q;
            A_MTVEC:             old_val = mtvec_q;
            A_MSCRATCH:          old_val = mscratch_q;
            A_MEPC:              old_val = mepc_q;
            A_MCAUSE:            old_val = mcause_q;
            A_MTVAL:             old_val = mtval_q;
            A_MIP:               old_val = '0;
            A_MHARTID:           old_val = HARTID;
            A_MCYCLE, A_CYCLE:   old_val = mcycle_q;
            A_MINSTRET, A_INSTRET: old_val = minstret_q;
            default:             impl    = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_req_op_i)
            2'b01:   new_val = csr_req_wdata_i;
            2'b10:   new_val = old_val | csr_req_wdata_i;
            2'b11:   new_val = old_val & ~csr_req_wdata_i;
            default: new_val = old_val;
        endcase
    end

    // Writes to the read-only space (addr[11:10]==11) are illegal even if the CSR exists
    assign wr_attempt = csr_req_wen_i && (csr_req_op_i != 2'b00);
    assign illegal    = !impl || (wr_attempt && (csr_req_addr_i[11:10] == 2'b11));
    assign accept     = csr_req_valid_i && csr_req_ready_o;
    assign do_write   = accept && wr_attempt && !illegal;
    assign ret_sat    = (retire_i == 2'd3) ? 2'd2 : retire_i;
    assign ret_inc    = {{(XLEN-2){1'b0}}, ret_sat};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= S_IDLE;
            csr_req_ready_o   <= 1'b1;
            csr_rsp_valid_o   <= 1'b0;
            csr_rsp_rdata_o   <= '0;
            csr_rsp_illegal_o <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q           <= S_RESP;
                        csr_req_ready_o   <= 1'b0;
                        csr_rsp_valid_o   <= 1'b1;
                        csr_rsp_rdata_o   <= illegal ? '0 : old_val;
                        csr_rsp_illegal_o <= illegal;
                    end
                end
                S_RESP: begin
                    if (csr_rsp_ready_i) begin
                        state_q         <= S_IDLE;
                        csr_req_ready_o <= 1'b1;
                        csr_rsp_valid_o <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Later assignments win: counter increment < CSR write < trap/mret
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mie_reg_q  <= '0;
            mtvec_q    <= MTVEC_RST & ALIGN_MASK;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_q + XLEN'(1);
            minstret_q <= minstret_q + ret_inc;
            if (do_write) begin
                case (csr_req_addr_i)
                    A_MSTATUS: begin
                        mie_q  <= new_val[3];
                        mpie_q <= new_val[7];
                    end
                    A_MIE:      mie_reg_q  <= new_val;
                    A_MTVEC:    mtvec_q    <= new_val & ALIGN_MASK;
                    A_MSCRATCH: mscratch_q <= new_val;
                    A_MEPC:     mepc_q     <= new_val & ALIGN_MASK;
                    A_MCAUSE:   mcause_q   <= new_val;
                    A_MTVAL:    mtval_q    <= new_val;
                    A_MCYCLE:   mcycle_q   <= new_val;
                    A_MINSTRET: minstret_q <= new_val;
                    default: ;
                endcase
            end
            if (trap_valid_i) begin
                mepc_q   <= trap_pc_i & ALIGN_MASK;
                mcause_q <= trap_cause_i;
                mtval_q  <= trap_tval_i;
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
            end else if (mret_i) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end
        end
    end

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;
    assign mie_o   = mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: driver pushes expected responses, a negedge
// monitor pops and compares them as the DUT hands responses over.
`timescale 1ns/1ps
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [11:0] req_addr;
    logic [1:0]  req_op;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_illegal;
    logic [31:0] rsp_rdata;
    logic [1:0]  retire;
    logic        trap_valid, mret;
    logic [31:0] trap_pc, trap_cause, trap_tval;
    logic [31:0] mtvec, mepc;
    logic        mie;

    csr_file #(.XLEN(32), .HARTID(32'h0), .MISA_VAL(32'h4000_0100), .MTVEC_RST(32'h0)) dut (
        .clk(clk), .rst(rst),
        .csr_req_valid_i(req_valid), .csr_req_ready_o(req_ready),
        .csr_req_addr_i(req_addr), .csr_req_op_i(req_op),
        .csr_req_wen_i(req_wen), .csr_req_wdata_i(req_wdata),
        .csr_rsp_valid_o(rsp_valid), .csr_rsp_ready_i(rsp_ready),
        .csr_rsp_rdata_o(rsp_rdata), .csr_rsp_illegal_o(rsp_illegal),
        .retire_i(retire), .trap_valid_i(trap_valid), .trap_pc_i(trap_pc),
        .trap_cause_i(trap_cause), .trap_tval_i(trap_tval), .mret_i(mret),
        .mtvec_o(mtvec), .mepc_o(mepc), .mie_o(mie)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        ill;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          edge_n;
    logic [31:0] mc_base;
    int          mc_base_edge;

    // Edge index since reset release; read right after a posedge it gives the pre-edge count
    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got rdata 0x%08h with nothing expected", rsp_rdata);
            end else begin
                e = sb.pop_front();
                check({e.name, ".rdata"}, rsp_rdata, e.rdata);
                check({e.name, ".illegal"}, 32'(rsp_illegal), 32'(e.ill));
            end
        end
    end

    // kind 1: expected rdata is the mcycle model value at the accept edge
    task automatic do_req(input string nm, input logic [11:0] a, input logic [1:0] op,
                          input logic wen, input logic [31:0] wd, input int kind,
                          input logic [31:0] er, input logic ei, input logic tr);
        logic ok;
        int   acc;
        exp_t e;
        req_valid = 1'b1; req_addr = a; req_op = op; req_wen = wen; req_wdata = wd;
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = req_ready;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s.accept: req_ready stayed 0 for 20 cycles, expected 1", nm);
            req_valid = 1'b0;
            return;
        end
        trap_valid = tr;
        @(posedge clk);
        acc = edge_n;
        e.name = nm;
        e.ill  = ei;
        e.rdata = (kind == 1) ? mc_base + 32'(acc - mc_base_edge) : er;
        sb.push_back(e);
        if (kind == 1 && a == 12'hB00 && wen && op == 2'b01) begin
            mc_base      = wd;
            mc_base_edge = acc + 1;
        end
        #1;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        trap_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = 0; req_addr = 0; req_op = 0; req_wen = 0; req_wdata = 0;
        rsp_ready = 1'b1; retire = 0; trap_valid = 0; mret = 0;
        trap_pc = 0; trap_cause = 0; trap_tval = 0;
        mc_base = 0; mc_base_edge = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("rst.req_ready", 32'(req_ready), 32'd1);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_rdata", rsp_rdata, 32'd0);
        check("rst.rsp_illegal", 32'(rsp_illegal), 32'd0);
        check("rst.mtvec_o", mtvec, 32'h0);
        check("rst.mepc_o", mepc, 32'h0);
        check("rst.mie_o", 32'(mie), 32'd0);

        do_req("mhartid", 12'hF14, 2'b00, 0, 0, 0, 32'h0, 0, 0);
        check("rsp_latency", 32'(rsp_valid), 32'd1);
        do_req("misa", 12'h301, 2'b00, 0, 0, 0, 32'h4000_0100, 0, 0);
        do_req("misa_wr", 12'h301, 2'b01, 1, 32'h1234, 0, 32'h4000_0100, 0, 0);
        do_req("misa_rd2", 12'h301, 2'b00, 0, 0, 0, 32'h4000_0100, 0, 0);

        do_req("mscratch_rw", 12'h340, 2'b01, 1, 32'hDEAD_BEEF, 0, 32'h0, 0, 0);
        do_req("mscratch_rs", 12'h340, 2'b10, 1, 32'h0000_F000, 0, 32'hDEAD_BEEF, 0, 0);
        do_req("mscratch_rc", 12'h340, 2'b11, 1, 32'hDEAD_0000, 0, 32'hDEAD_FEEF, 0, 0);
        do_req("mscratch_rd", 12'h340, 2'b00, 0, 0, 0, 32'h0000_FEEF, 0, 0);
        do_req("mscratch_rs_nowen", 12'h340, 2'b10, 0, 32'hFFFF_FFFF, 0, 32'h0000_FEEF, 0, 0);
        do_req("mscratch_rd2", 12'h340, 2'b00, 0, 0, 0, 32'h0000_FEEF, 0, 0);

        do_req("cycle_wr", 12'hC00, 2'b01, 1, 32'h1234, 0, 32'h0, 1, 0);
        do_req("mcycle_rd", 12'hB00, 2'b00, 0, 0, 1, 32'h0, 0, 0);
        do_req("unimpl_7c0", 12'h7C0, 2'b00, 0, 0, 0, 32'h0, 1, 0);
        do_req("mhartid_wr", 12'hF14, 2'b01, 1, 32'h5, 0, 32'h0, 1, 0);
        do_req("mip_wr", 12'h344, 2'b01, 1, 32'hFFFF_FFFF, 0, 32'h0, 0, 0);
        do_req("mip_rd", 12'h344, 2'b00, 0, 0, 0, 32'h0, 0, 0);

        do_req("mcycle_wr", 12'hB00, 2'b01, 1, 32'hFFFF_FFFE, 1, 32'h0, 0, 0);
        idle(3);
        do_req("mcycle_wrap", 12'hB00, 2'b00, 0, 0, 1, 32'h0, 0, 0);
        do_req("cycle_shadow", 12'hC00, 2'b00, 0, 0, 1, 32'h0, 0, 0);

        do_req("minstret_0", 12'hB02, 2'b00, 0, 0, 0, 32'd0, 0, 0);
        retire = 2'd2;
        idle(5);
        retire = 2'd0;
        do_req("minstret_10", 12'hB02, 2'b00, 0, 0, 0, 32'd10, 0, 0);
        retire = 2'd3;
        idle(1);
        retire = 2'd0;
        do_req("instret_sat", 12'hC02, 2'b00, 0, 0, 0, 32'd12, 0, 0);

        do_req("mtvec_wr", 12'h305, 2'b01, 1, 32'h0000_1003, 0, 32'h0, 0, 0);
        check("mtvec_o", mtvec, 32'h0000_1000);
        do_req("mtvec_rd", 12'h305, 2'b00, 0, 0, 0, 32'h0000_1000, 0, 0);
        do_req("mepc_wr", 12'h341, 2'b01, 1, 32'h0000_0207, 0, 32'h0, 0, 0);
        check("mepc_o.wr", mepc, 32'h0000_0204);
        do_req("mepc_rd", 12'h341, 2'b00, 0, 0, 0, 32'h0000_0204, 0, 0);

        do_req("mstatus_wr", 12'h300, 2'b01, 1, 32'h0000_000F, 0, 32'h0, 0, 0);
        check("mie_o.set", 32'(mie), 32'd1);
        do_req("mstatus_rd", 12'h300, 2'b00, 0, 0, 0, 32'h0000_0008, 0, 0);

        trap_pc = 32'h103; trap_cause = 32'd11; trap_tval = 32'hBAD;
        trap_valid = 1'b1;
        idle(1);
        trap_valid = 1'b0;
        check("mepc_o.trap", mepc, 32'h0000_0100);
        check("mie_o.trap", 32'(mie), 32'd0);
        do_req("trap.mepc", 12'h341, 2'b00, 0, 0, 0, 32'h0000_0100, 0, 0);
        do_req("trap.mcause", 12'h342, 2'b00, 0, 0, 0, 32'd11, 0, 0);
        do_req("trap.mtval", 12'h343, 2'b00, 0, 0, 0, 32'hBAD, 0, 0);
        do_req("trap.mstatus", 12'h300, 2'b00, 0, 0, 0, 32'h0000_0080, 0, 0);

        mret = 1'b1;
        idle(1);
        mret = 1'b0;
        check("mie_o.mret", 32'(mie), 32'd1);
        do_req("mret.mstatus", 12'h300, 2'b00, 0, 0, 0, 32'h0000_0088, 0, 0);

        trap_pc = 32'h40; trap_cause = 32'd3; trap_tval = 32'h0;
        trap_valid = 1'b1; mret = 1'b1;
        idle(1);
        trap_valid = 1'b0; mret = 1'b0;
        check("mie_o.trap_mret", 32'(mie), 32'd0);
        do_req("trap_mret.mstatus", 12'h300, 2'b00, 0, 0, 0, 32'h0000_0080, 0, 0);

        trap_pc = 32'h2002; trap_cause = 32'd7; trap_tval = 32'h77;
        do_req("mepc_wr_trap", 12'h341, 2'b01, 1, 32'h5555_0000, 0, 32'h0000_0040, 0, 1);
        check("mepc_o.trap_wins", mepc, 32'h0000_2000);
        do_req("mepc_rd_trap", 12'h341, 2'b00, 0, 0, 0, 32'h0000_2000, 0, 0);
        do_req("mscratch_wr_trap", 12'h340, 2'b01, 1, 32'h1234_5678, 0, 32'h0000_FEEF, 0, 1);
        do_req("mscratch_rd_trap", 12'h340, 2'b00, 0, 0, 0, 32'h1234_5678, 0, 0);
        do_req("mcause_rd_trap", 12'h342, 2'b00, 0, 0, 0, 32'd7, 0, 0);

        // Response back-pressure with a second request waiting
        idle(2);
        rsp_ready = 1'b0;
        do_req("bp.first", 12'h340, 2'b00, 0, 0, 0, 32'h1234_5678, 0, 0);
        req_valid = 1'b1; req_addr = 12'h342; req_op = 2'b00; req_wen = 1'b0; req_wdata = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp.req_ready", 32'(req_ready), 32'd0);
            check("bp.rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp.rsp_rdata", rsp_rdata, 32'h1234_5678);
            check("bp.rsp_illegal", 32'(rsp_illegal), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp.ready_after", 32'(req_ready), 32'd1);
        check("bp.valid_after", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        begin
            exp_t e;
            e.name = "bp.second"; e.rdata = 32'd7; e.ill = 1'b0;
            sb.push_back(e);
        end
        #1 req_valid = 1'b0;

        // Reset in the middle of a pending response
        idle(3);
        do_req("rst_mid", 12'h340, 2'b00, 0, 0, 0, 32'h1234_5678, 0, 0);
        rst = 1'b1;
        #1;
        check("rst_mid.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid.req_ready", 32'(req_ready), 32'd1);
        void'(sb.pop_back());
        mc_base = 0; mc_base_edge = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        do_req("rst_mid.mscratch", 12'h340, 2'b00, 0, 0, 0, 32'h0, 0, 0);
        do_req("rst_mid.mtvec", 12'h305, 2'b00, 0, 0, 0, 32'h0, 0, 0);
        do_req("rst_mid.mcycle", 12'hB00, 2'b00, 0, 0, 1, 32'h0, 0, 0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
